// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Consumer-side adapter for the FIFO_Buffer read port. It issues read
//   enables to the FIFO, catches each word one cycle later in a 2-entry skid
//   buffer, and presents the words as a valid/ready stream. It sustains one
//   word per cycle, keeps order, and never drops or repeats a word under
//   backpressure.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   fifo_data_i    FIFO read data, valid the cycle after fifo_rden_o was high
//   fifo_empty_i   FIFO empty flag
//   fifo_rden_o    FIFO read enable (combinational)
//   flush_i        synchronous discard of buffered and in-flight words
//   data_o         stream data (skid-buffer head)
//   valid_o        stream valid
//   ready_i        downstream ready
//   word_count_o   words delivered (stats build only, else 0)
//   stall_count_o  cycles with valid_o & ~ready_i (stats build only, else 0)
//
// Build option
//   STREAM_READER_STATS_EN : when defined, adds saturating 32-bit counters
//   for delivered words and backpressure cycles. Reset clears them; flush
//   does not.

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rden_o,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [31:0]           word_count_o,
  output logic [31:0]           stall_count_o
);

  // Skid-buffer occupancy.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  inflight_reg;
  logic [DATA_WIDTH-1:0] head_reg, head_next;
  logic [DATA_WIDTH-1:0] tail_reg, tail_next;

  logic       pop;
  logic       push;
  logic [1:0] occupancy;
  logic       has_credit;

  assign valid_o = (state_reg != S_EMPTY);
  assign data_o  = head_reg;
  assign pop     = valid_o & ready_i;
  assign push    = inflight_reg;

  // Words held plus the word on its way from the FIFO. This never exceeds 2,
  // so a 2-bit sum cannot wrap.
  assign occupancy = state_reg + {1'b0, inflight_reg};

  // credits = 2 - occupancy + pop > 0  <=>  occupancy < 2 + pop.
  // Because a read issued now lands next cycle, reserving a slot for every
  // in-flight word is what keeps the buffer from ever needing a third entry.
  assign has_credit = (occupancy < 2'd2) | (pop & (occupancy == 2'd2));

  assign fifo_rden_o = ~reset & ~flush_i & ~fifo_empty_i & has_credit;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (flush_i) begin
      // Any pop this cycle still completes because the stream outputs come
      // straight from state; the arriving word is simply not captured.
      state_next = S_EMPTY;
    end else begin
      unique case (state_reg)
        S_EMPTY: begin
          if (push) begin
            head_next  = fifo_data_i;
            state_next = S_ONE;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head_next = fifo_data_i;
          end else if (push) begin
            tail_next  = fifo_data_i;
            state_next = S_TWO;
          end else if (pop) begin
            state_next = S_EMPTY;
          end
        end
        S_TWO: begin
          // Push without pop cannot happen here: the credit rule withheld
          // the read that would have produced it.
          if (pop) begin
            head_next = tail_reg;
            if (push) begin
              tail_next = fifo_data_i;
            end else begin
              state_next = S_ONE;
            end
          end
        end
        default: begin
          state_next = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_EMPTY;
      inflight_reg <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_rden_o;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
    end
  end

`ifdef STREAM_READER_STATS_EN
  // Index 0 counts delivered words, index 1 counts backpressure cycles.
  logic [1:0]  stat_inc;
  logic [31:0] stat_vec [2];

  assign stat_inc = {valid_o & ~ready_i, pop};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stat
      logic [31:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (stat_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end

      assign stat_vec[gi] = cnt_reg;
    end
  endgenerate

  assign word_count_o  = stat_vec[0];
  assign stall_count_o = stat_vec[1];
`else
  assign word_count_o  = '0;
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed testbench for fifo_stream_reader. A small behavioural FIFO with
// one-cycle read latency feeds the DUT; a scoreboard tracks every word the
// FIFO hands out and checks each delivered word, the credit rule and hold
// stability on every cycle.

module tb_fifo_stream_reader;

  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          ready;
  logic          empty;
  logic          rden;
  logic          valid;
  logic [DW-1:0] fdata;
  logic [DW-1:0] dout;
  logic [31:0]   wc;
  logic [31:0]   sc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_data_i  (fdata),
    .fifo_empty_i (empty),
    .fifo_rden_o  (rden),
    .flush_i      (flush),
    .data_o       (dout),
    .valid_o      (valid),
    .ready_i      (ready),
    .word_count_o (wc),
    .stall_count_o(sc)
  );

  // Behavioural FIFO: registered read data, cleared by the shared reset.
  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (reset) begin
      rd_ptr <= wr_ptr;
    end else if (rden) begin
      fdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // One clock cycle: per-cycle scoreboard checks, then advance to 1 ns past
  // the next rising edge.
  task automatic cyc();
    logic          p;
    int            occ;
    logic [DW-1:0] e;
    #1;
    p   = valid & ready & ~reset;
    occ = exp_q.size();
    chk("rden_into_empty", {63'd0, rden & empty}, 64'd0);
    chk("rden_without_credit", {63'd0, rden && ((occ - int'(p)) >= 2)}, 64'd0);
    chk("occupancy_le_2", {63'd0, occ <= 2}, 64'd1);
    if (hold_pending) chk("hold_stable", dout, hold_val);
    if (p) begin
      chk("pop_has_expected", {63'd0, occ != 0}, 64'd1);
      if (occ != 0) begin
        e = exp_q.pop_front();
        chk("pop_data", dout, e);
      end
      got_q.push_back(dout);
    end
    hold_pending = valid & ~ready & ~reset & ~flush;
    hold_val     = dout;
    if (reset || flush) exp_q.delete();
    if (rden) exp_q.push_back(mem[rd_ptr]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    ready = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_valid", valid, 0);
    chk("rst_data", dout, 0);
    chk("rst_rden", rden, 0);
    chk("rst_word_count", wc, 0);
    chk("rst_stall_count", sc, 0);

    // Test 1: three preloaded words, ready high
    push_word(36'hA_0000_000A);
    push_word(36'hB_0000_000B);
    push_word(36'hC_0000_000C);
    reset = 1'b0;
    ready = 1'b1;
    #1;
    chk("t1_c0_rden", rden, 1);
    chk("t1_c0_valid", valid, 0);
    cyc();
    chk("t1_c1_rden", rden, 1);
    chk("t1_c1_valid", valid, 0);
    cyc();
    chk("t1_c2_rden", rden, 1);
    chk("t1_c2_valid", valid, 1);
    chk("t1_c2_data", dout, 36'hA_0000_000A);
    cyc();
    chk("t1_c3_rden", rden, 0);
    chk("t1_c3_valid", valid, 1);
    chk("t1_c3_data", dout, 36'hB_0000_000B);
    cyc();
    chk("t1_c4_valid", valid, 1);
    chk("t1_c4_data", dout, 36'hC_0000_000C);
    cyc();
    chk("t1_c5_valid", valid, 0);

    // Test 2: eight words under a backpressure pattern
    begin
      logic [11:0] pat;
      int          guard;
      pat = 12'b1111_1110_1100;  // applied LSB first: 0,0,1,1,0,1,1,1,... reversed below
      pat = 12'b1111_1101_1001;  // bit i = ready in step i: 1,0,0,1,1,0,1,1,1,1,1,1
      got_q.delete();
      for (int i = 0; i < 8; i++) push_word(36'h200 + DW'(i));
      for (int i = 0; i < 12; i++) begin
        ready = pat[i];
        cyc();
      end
      ready = 1'b1;
      guard = 0;
      while (got_q.size() < 8 && guard < 40) begin
        cyc();
        guard++;
      end
      chk("t2_delivered", got_q.size(), 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++)
        chk("t2_order", got_q[i], 36'h200 + DW'(i));
      cyc();
    end

    // Test 3: FIFO empty for 10 cycles, then a single write
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t3_idle_rden", rden, 0);
      chk("t3_idle_valid", valid, 0);
    end
    push_word(36'h3AA);
    #1;
    chk("t3_rden_issue", rden, 1);
    cyc();
    chk("t3_valid_n1", valid, 0);
    cyc();
    chk("t3_valid_n2", valid, 1);
    chk("t3_data_n2", dout, 36'h3AA);
    cyc();
    chk("t3_drained", valid, 0);

    // Test 4: flush with a word in flight, then flush with a full buffer
    got_q.delete();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(36'h400 + DW'(i));
    #1;
    chk("t4_c0_rden", rden, 1);
    cyc();
    cyc();
    flush = 1'b1;
    #1;
    chk("t4_flush_rden", rden, 0);
    chk("t4_flush_valid", valid, 1);
    chk("t4_flush_head", dout, 36'h400);
    cyc();
    flush = 1'b0;
    #1;
    chk("t4_post_valid", valid, 0);
    chk("t4_resume_rden", rden, 1);
    cyc();
    chk("t4_c4_valid", valid, 0);
    cyc();
    chk("t4_c5_valid", valid, 1);
    chk("t4_c5_data", dout, 36'h402);
    cyc();
    chk("t4_c6_data", dout, 36'h402);
    flush = 1'b1;
    ready = 1'b1;
    cyc();
    flush = 1'b0;
    ready = 1'b0;
    chk("t4_full_flush_valid", valid, 0);
    ready = 1'b1;
    repeat (8) cyc();
    chk("t4_delivered", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("t4_word0", got_q[0], 36'h402);
      chk("t4_word1", got_q[1], 36'h404);
      chk("t4_word2", got_q[2], 36'h405);
    end

    // Test 5: reset mid-stream with a full buffer
    ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(36'h500 + DW'(i));
    repeat (4) cyc();
    chk("t5_full_valid", valid, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_rden", rden, 0);
    cyc();
    chk("t5_rst_valid", valid, 0);
    chk("t5_rst_data", dout, 0);
    chk("t5_rst_wc", wc, 0);
    chk("t5_rst_sc", sc, 0);
    reset = 1'b0;
    got_q.delete();
    push_word(36'h5F0);
    push_word(36'h5F1);
    ready = 1'b1;
    repeat (6) cyc();
    chk("t5_delivered", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t5_word0", got_q[0], 36'h5F0);
      chk("t5_word1", got_q[1], 36'h5F1);
    end

    // Test 6: five pops and three stall cycles
    reset = 1'b1;
    ready = 1'b0;
    cyc();
    reset = 1'b0;
    got_q.delete();
    for (int i = 0; i < 5; i++) push_word(36'h600 + DW'(i));
    cyc();
    cyc();
    chk("t6_stall_start_valid", valid, 1);
    repeat (3) cyc();
    ready = 1'b1;
    repeat (10) cyc();
    chk("t6_delivered", got_q.size(), 5);
`ifdef STREAM_READER_STATS_EN
    chk("t6_word_count", wc, 5);
    chk("t6_stall_count", sc, 3);
`else
    chk("t6_word_count_off", wc, 0);
    chk("t6_stall_count_off", sc, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
